// File: rtl/ks_pkg.sv
// Shared helpers for the pipelined Kogge-Stone adder: log2 and pipeline depth.
package ks_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int unsigned ks_depth(input int unsigned width);
        return clog2(width) + 2;
    endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// One Kogge-Stone prefix level: combines each position with the one SPAN below it.
module ks_prefix_level #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SPAN  = 1
) (
    input  logic [WIDTH-1:0] g_in,
    input  logic [WIDTH-1:0] p_in,
    output logic [WIDTH-1:0] g_out,
    output logic [WIDTH-1:0] p_out
);

    // Low SPAN positions have no partner; forcing their partner P to 1 passes them through.
    localparam logic [WIDTH-1:0] LOW_MASK = {WIDTH{1'b1}} >> (WIDTH - SPAN);

    assign g_out = g_in | (p_in & (g_in << SPAN));
    assign p_out = p_in & ((p_in << SPAN) | LOW_MASK);

endmodule

// File: rtl/ks_pipe_adder.sv
// Pipelined, back-pressurable Kogge-Stone adder with valid/ready on both sides.
// Optional signed-overflow output enabled by defining KS_OVF_EN.
module ks_pipe_adder
    import ks_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             c0,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out,
    output logic [TAG_W-1:0] out_tag
`ifdef KS_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned LEVELS = clog2(WIDTH);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             c0;
        logic [TAG_W-1:0] tag;
    } in_t;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] pg;
        logic             c0;
        logic [TAG_W-1:0] tag;
`ifdef KS_OVF_EN
        logic             sa;
        logic             sb;
`endif
    } stage_t;

    in_t              in_q;
    stage_t           st_q [0:LEVELS];
    stage_t           st_d [0:LEVELS];
    logic [WIDTH-1:0] lev_g [1:LEVELS];
    logic [WIDTH-1:0] lev_p [1:LEVELS];
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum;
    logic             stall;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
        ks_prefix_level #(
            .WIDTH (WIDTH),
            .SPAN  (1 << (k - 1))
        ) u_level (
            .g_in  (st_q[k-1].g),
            .p_in  (st_q[k-1].pg),
            .g_out (lev_g[k]),
            .p_out (lev_p[k])
        );
    end

    // Stage 0 generates bitwise g/p with the carry-in folded into bit 0; later stages take a prefix level.
    always_comb begin
        st_d[0]       = '0;
        st_d[0].valid = in_q.valid;
        st_d[0].p     = in_q.a ^ in_q.b;
        st_d[0].g     = in_q.a & in_q.b;
        st_d[0].g[0]  = (in_q.a[0] & in_q.b[0]) | ((in_q.a[0] ^ in_q.b[0]) & in_q.c0);
        st_d[0].pg    = in_q.a ^ in_q.b;
        st_d[0].c0    = in_q.c0;
        st_d[0].tag   = in_q.tag;
`ifdef KS_OVF_EN
        st_d[0].sa    = in_q.a[WIDTH-1];
        st_d[0].sb    = in_q.b[WIDTH-1];
`endif
        for (int k = 1; k <= int'(LEVELS); k++) begin
            st_d[k]    = st_q[k-1];
            st_d[k].g  = lev_g[k];
            st_d[k].pg = lev_p[k];
        end
    end

    assign carry = st_q[LEVELS].g;
    assign sum   = st_q[LEVELS].p ^ {carry[WIDTH-2:0], st_q[LEVELS].c0};

    // Global stall: every register holds together; result data only loads on a valid result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_q.valid <= 1'b0;
            for (int k = 0; k <= int'(LEVELS); k++) begin
                st_q[k].valid <= 1'b0;
            end
            out_valid <= 1'b0;
            out       <= '0;
            out_tag   <= '0;
`ifdef KS_OVF_EN
            ovf       <= 1'b0;
`endif
        end else if (!stall) begin
            in_q.valid <= in_valid;
            in_q.a     <= in1;
            in_q.b     <= in2;
            in_q.c0    <= c0;
            in_q.tag   <= in_tag;
            for (int k = 0; k <= int'(LEVELS); k++) begin
                st_q[k] <= st_d[k];
            end
            out_valid <= st_q[LEVELS].valid;
            if (st_q[LEVELS].valid) begin
                out     <= {carry[WIDTH-1], sum};
                out_tag <= st_q[LEVELS].tag;
`ifdef KS_OVF_EN
                ovf     <= (st_q[LEVELS].sa == st_q[LEVELS].sb) & (sum[WIDTH-1] != st_q[LEVELS].sa);
`endif
            end
        end
    end

endmodule

// File: tb/tb_ks_pipe_adder.sv
// Self-checking bench for ks_pipe_adder: vector table, scoreboard, back-pressure and reset corners.
module tb_ks_pipe_adder;

    localparam int unsigned W  = 32;
    localparam int unsigned TW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in1;
    logic [W-1:0]  in2;
    logic          c0;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W:0]    out;
    logic [TW-1:0] out_tag;
`ifdef KS_OVF_EN
    logic          ovf;
`endif

    always #5 clk = ~clk;

    ks_pipe_adder #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .c0        (c0),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_tag   (out_tag)
`ifdef KS_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    typedef struct packed {
        logic [W:0]    out;
        logic [TW-1:0] tag;
        logic          ovf;
    } res_t;

    typedef struct packed {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          c;
        logic [TW-1:0] tag;
        logic [W:0]    exp_out;
        logic          exp_ovf;
    } vec_t;

    res_t sb_q[$];
    res_t mon_exp;
    int   checks    = 0;
    int   errors    = 0;
    int   pushed    = 0;
    int   delivered = 0;

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic [TW-1:0] t);
        res_t r;
        r.out = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        r.tag = t;
        r.ovf = (a[W-1] == b[W-1]) && (r.out[W-1] != a[W-1]);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic [TW-1:0] t);
        in_valid = 1'b1;
        in1      = a;
        in2      = b;
        c0       = c;
        in_tag   = t;
    endtask

    task automatic drive_rand();
        drive($urandom(), $urandom(), 1'($urandom_range(0, 1)), TW'($urandom()));
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 64'(sb_q.size()), 64'd0);
    endtask

    // Scoreboard: push on accepted input, pop and compare on delivered output.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", 64'd1, 64'd0);
                end else begin
                    mon_exp = sb_q.pop_front();
                    check("sb_out", 64'(out), 64'(mon_exp.out));
                    check("sb_tag", 64'(out_tag), 64'(mon_exp.tag));
`ifdef KS_OVF_EN
                    check("sb_ovf", 64'(ovf), 64'(mon_exp.ovf));
`endif
                    delivered++;
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(model(in1, in2, c0, in_tag));
                pushed++;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs [7];
        int   lat;
        int   cnt;
        int   base;
        logic [W:0]    held_out;
        logic [TW-1:0] held_tag;

        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 8'h11, 33'h1_0000_0000, 1'b0};
        vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 8'h22, 33'h0_8000_0000, 1'b1};
        vecs[2] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 8'h33, 33'h0_0000_0000, 1'b0};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 8'h44, 33'h1_FFFF_FFFF, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 8'h55, 33'h1_0000_0000, 1'b1};
        vecs[5] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 8'h66, 33'h0_ACF1_3568, 1'b0};
        vecs[6] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 8'h77, 33'h1_0000_0000, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in1       = '0;
        in2       = '0;
        c0        = 1'b0;
        in_tag    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out", 64'(out), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef KS_OVF_EN
        check("rst_ovf", 64'(ovf), 64'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", 64'(in_ready), 64'd1);

        // Isolated vectors: latency and value against the table.
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].tag);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat = 0;
            do begin
                @(posedge clk);
                #1;
                lat++;
            end while (!out_valid && lat < 30);
            check("vec_latency", 64'(lat), 64'd7);
            check("vec_out", 64'(out), 64'(vecs[i].exp_out));
            check("vec_tag", 64'(out_tag), 64'(vecs[i].tag));
`ifdef KS_OVF_EN
            check("vec_ovf", 64'(ovf), 64'(vecs[i].exp_ovf));
`endif
            @(posedge clk);
            #1;
        end

        // Back-to-back streaming with the consumer always ready.
        base = delivered;
        cnt  = 0;
        for (int i = 0; i < 10000; i++) begin
            drive_rand();
            if (!in_ready) cnt++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("stream_in_ready_low_cycles", 64'(cnt), 64'd0);
        lat = 0;
        while (!(out_valid && sb_q.size() == 1) && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("stream_last_latency", 64'(lat), 64'd7);
        @(posedge clk);
        #1;
        check("stream_delivered", 64'(delivered - base), 64'd10000);
        check("stream_queue_empty", 64'(sb_q.size()), 64'd0);

        // Back-pressure: fill with the consumer stalled, then hold 20 cycles.
        out_ready = 1'b0;
        cnt = 0;
        drive_rand();
        while (in_ready && cnt < 40) begin
            @(posedge clk);
            #1;
            drive_rand();
            cnt++;
        end
        check("bp_in_ready_dropped", 64'(in_ready), 64'd0);
        held_out = out;
        held_tag = out_tag;
        base     = pushed;
        cnt      = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            drive_rand();
            if (out !== held_out || out_tag !== held_tag || in_ready || !out_valid) cnt++;
        end
        check("bp_hold_unstable_cycles", 64'(cnt), 64'd0);
        check("bp_no_accept", 64'(pushed - base), 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("bp_drain");
        check("bp_count", 64'(delivered), 64'(pushed));

        // Random valid and ready.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 1) drive_rand();
            else in_valid = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("rand_drain");
        check("rand_count", 64'(delivered), 64'(pushed));

        // Reset with four transactions in flight.
        for (int i = 0; i < 4; i++) begin
            drive_rand();
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        sb_q.delete();
        @(posedge clk);
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out", 64'(out), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        base  = delivered;
        cnt   = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (out_valid) cnt++;
        end
        check("mid_rst_no_output", 64'(cnt), 64'd0);
        check("mid_rst_delivered", 64'(delivered - base), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
